fb_scanout: RTL and testbench

//  Read-side master for the 128x128, 6-bit dual-port framebuffer.

---
 rtl/fb_scanout.sv | 170 +++++++++++++++++
 tb/tb_fb_scanout.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// VGA scan-out master for a 128x128 RGB222 framebuffer: generates timing, drives the
// registered read port and shows the image upscaled in a centred window with a border.
module fb_scanout #(
  parameter int         H_ACTIVE   = 640,
  parameter int         H_FP       = 16,
  parameter int         H_SYNC     = 96,
  parameter int         H_BP       = 48,
  parameter int         V_ACTIVE   = 480,
  parameter int         V_FP       = 10,
  parameter int         V_SYNC     = 2,
  parameter int         V_BP       = 33,
  parameter bit         HS_POL     = 1'b0,
  parameter bit         VS_POL     = 1'b0,
  parameter int         X_OFF      = 192,
  parameter int         Y_OFF      = 112,
  parameter int         SCALE_LOG2 = 1,
  parameter logic [5:0] BORDER     = 6'b000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [13:0] rd_addr,
  input  logic [5:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [1:0]  red,
  output logic [1:0]  green,
  output logic [1:0]  blue,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WIN     = 128 << SCALE_LOG2;

  // 10-bit counters cover 800x525 and every window edge of the default geometry.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_LO     = 10'(X_OFF);
  localparam logic [9:0] X_HI     = 10'(X_OFF + WIN);
  localparam logic [9:0] Y_LO     = 10'(Y_OFF);
  localparam logic [9:0] Y_HI     = 10'(Y_OFF + WIN);

  logic [9:0] h_q, h_d, v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 1 inputs: with en low every flag is forced to its blank value.
  logic [9:0]  dx, dy;
  logic        in_win;
  logic        vis1_d, win1_d, hs1_d, vs1_d, vb1_d, fs1_d;
  logic [13:0] addr_d;

  always_comb begin
    dx     = h_q - X_LO;
    dy     = v_q - Y_LO;
    in_win = (h_q >= X_LO) && (h_q < X_HI) && (v_q >= Y_LO) && (v_q < Y_HI);
    vis1_d = en && (h_q < H_ACT) && (v_q < V_ACT);
    win1_d = en && in_win;
    hs1_d  = en && (h_q >= HS_START) && (h_q < HS_END);
    vs1_d  = en && (v_q >= VS_START) && (v_q < VS_END);
    vb1_d  = en && (v_q >= V_ACT);
    fs1_d  = en && (h_q == '0) && (v_q == '0);
    addr_d = win1_d ? {7'(dy >> SCALE_LOG2), 7'(dx >> SCALE_LOG2)} : '0;
  end

  logic [13:0] addr_q;
  logic        vis1_q, win1_q, hs1_q, vs1_q, vb1_q, fs1_q;
  logic        vis2_q, win2_q, hs2_q, vs2_q, vb2_q, fs2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      vis1_q <= 1'b0;
      win1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      vis2_q <= 1'b0;
      win2_q <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      vb2_q  <= 1'b0;
      fs2_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      vis1_q <= vis1_d;
      win1_q <= win1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      vb1_q  <= vb1_d;
      fs1_q  <= fs1_d;
      // Stage 2 flags wait here while the framebuffer registers rd_data.
      vis2_q <= vis1_q;
      win2_q <= win1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      vb2_q  <= vb1_q;
      fs2_q  <= fs1_q;
    end
  end

  logic [5:0] rgb_d, rgb_q;
  logic       de_q, hsync_q, vsync_q, vblank_q, fs_q;

  always_comb begin
    rgb_d = '0;
    if (vis2_q) rgb_d = win2_q ? rd_data : BORDER;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_q     <= vis2_q;
      hsync_q  <= hs2_q ? HS_POL : ~HS_POL;
      vsync_q  <= vs2_q ? VS_POL : ~VS_POL;
      vblank_q <= vb2_q;
      fs_q     <= fs2_q;
    end
  end

  assign rd_addr     = addr_q;
  assign de          = de_q;
  assign red         = rgb_q[5:4];
  assign green       = rgb_q[3:2];
  assign blue        = rgb_q[1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vblank      = vblank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: two reduced geometries (2x scaled/clipped, 1x fully framed)
// against a linear-scan-index reference model with a randomly filled framebuffer.
module tb_fb_scanout;

  localparam int H_A [2] = '{80, 144};
  localparam int H_F [2] = '{4, 4};
  localparam int H_S [2] = '{6, 8};
  localparam int H_B [2] = '{6, 4};
  localparam int V_A [2] = '{48, 136};
  localparam int V_F [2] = '{2, 2};
  localparam int V_S [2] = '{3, 2};
  localparam int V_B [2] = '{3, 4};
  localparam bit HPOL[2] = '{1'b1, 1'b0};
  localparam bit VPOL[2] = '{1'b1, 1'b0};
  localparam int XO  [2] = '{6, 8};
  localparam int YO  [2] = '{4, 4};
  localparam int SC  [2] = '{1, 0};
  localparam logic [5:0] BORDER = 6'h2A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic [5:0] mem [16384];

  logic [13:0] rd_addr_a, rd_addr_b;
  logic [5:0]  rd_data_a, rd_data_b;
  logic        hsync_a, vsync_a, de_a, vblank_a, fs_a;
  logic        hsync_b, vsync_b, de_b, vblank_b, fs_b;
  logic [1:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

  fb_scanout #(
    .H_ACTIVE(H_A[0]), .H_FP(H_F[0]), .H_SYNC(H_S[0]), .H_BP(H_B[0]),
    .V_ACTIVE(V_A[0]), .V_FP(V_F[0]), .V_SYNC(V_S[0]), .V_BP(V_B[0]),
    .HS_POL(HPOL[0]), .VS_POL(VPOL[0]), .X_OFF(XO[0]), .Y_OFF(YO[0]),
    .SCALE_LOG2(SC[0]), .BORDER(BORDER)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .red(red_a), .green(green_a),
    .blue(blue_a), .vblank(vblank_a), .frame_start(fs_a)
  );

  fb_scanout #(
    .H_ACTIVE(H_A[1]), .H_FP(H_F[1]), .H_SYNC(H_S[1]), .H_BP(H_B[1]),
    .V_ACTIVE(V_A[1]), .V_FP(V_F[1]), .V_SYNC(V_S[1]), .V_BP(V_B[1]),
    .HS_POL(HPOL[1]), .VS_POL(VPOL[1]), .X_OFF(XO[1]), .Y_OFF(YO[1]),
    .SCALE_LOG2(SC[1]), .BORDER(BORDER)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .red(red_b), .green(green_b),
    .blue(blue_b), .vblank(vblank_b), .frame_start(fs_b)
  );

  // Framebuffer read ports with one cycle of registered latency.
  always @(posedge clk) begin
    rd_data_a <= mem[rd_addr_a];
    rd_data_b <= mem[rd_addr_b];
  end

  logic [10:0] obs_a, obs_b;
  assign obs_a = {de_a, red_a, green_a, blue_a, hsync_a, vsync_a, vblank_a, fs_a};
  assign obs_b = {de_b, red_b, green_b, blue_b, hsync_b, vsync_b, vblank_b, fs_b};

  logic [10:0] exp_qa[$];
  logic [10:0] exp_qb[$];
  int s_a, s_b;
  int n_chk, n_fail;
  logic mon_on;

  function automatic int h_tot(input int c);
    return H_A[c] + H_F[c] + H_S[c] + H_B[c];
  endfunction

  function automatic int f_tot(input int c);
    return h_tot(c) * (V_A[c] + V_F[c] + V_S[c] + V_B[c]);
  endfunction

  // Expected {de, rgb, hsync, vsync, vblank, frame_start} for scan index s of config c.
  function automatic logic [10:0] model_px(input int c, input int s, input logic e);
    int h, v, wend, fbx, fby;
    logic vis, win, hs, vs, vb, fs;
    logic [5:0] rgb;
    if (!e) return {1'b0, 6'd0, ~HPOL[c], ~VPOL[c], 1'b0, 1'b0};
    h    = s % h_tot(c);
    v    = s / h_tot(c);
    wend = 128 << SC[c];
    vis  = (h < H_A[c]) && (v < V_A[c]);
    win  = (h >= XO[c]) && (h < XO[c] + wend) && (v >= YO[c]) && (v < YO[c] + wend);
    fbx  = (h - XO[c]) / (1 << SC[c]);
    fby  = (v - YO[c]) / (1 << SC[c]);
    rgb  = 6'd0;
    if (vis) rgb = win ? mem[fby * 128 + fbx] : BORDER;
    hs = ((h >= H_A[c] + H_F[c]) && (h < H_A[c] + H_F[c] + H_S[c])) ? HPOL[c] : ~HPOL[c];
    vs = ((v >= V_A[c] + V_F[c]) && (v < V_A[c] + V_F[c] + V_S[c])) ? VPOL[c] : ~VPOL[c];
    vb = (v >= V_A[c]);
    fs = (s == 0);
    return {vis, rgb, hs, vs, vb, fs};
  endfunction

  // Sets en for the coming edge and queues the output expected two edges after it.
  task automatic drive(input logic e);
    en = e;
    exp_qa.push_back(model_px(0, s_a, e));
    exp_qb.push_back(model_px(1, s_b, e));
    s_a = e ? (s_a + 1) % f_tot(0) : 0;
    s_b = e ? (s_b + 1) % f_tot(1) : 0;
  endtask

  task automatic check_rst(input string tag);
    n_chk++;
    if (obs_a !== model_px(0, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL %s_a_out t=%0t got=%b want=%b", tag, $time, obs_a, model_px(0, 0, 1'b0));
    end
    n_chk++;
    if (rd_addr_a !== 14'd0) begin
      n_fail++;
      $display("FAIL %s_a_addr t=%0t got=%h want=0", tag, $time, rd_addr_a);
    end
    n_chk++;
    if (obs_b !== model_px(1, 0, 1'b0)) begin
      n_fail++;
      $display("FAIL %s_b_out t=%0t got=%b want=%b", tag, $time, obs_b, model_px(1, 0, 1'b0));
    end
    n_chk++;
    if (rd_addr_b !== 14'd0) begin
      n_fail++;
      $display("FAIL %s_b_addr t=%0t got=%h want=0", tag, $time, rd_addr_b);
    end
  endtask

  // Monitor: one comparison per instance for every output cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      logic [10:0] want;
      n_chk++;
      if (exp_qa.size() == 0) begin
        n_fail++;
        $display("FAIL scan_a t=%0t expected queue empty", $time);
      end else begin
        want = exp_qa.pop_front();
        if (obs_a !== want) begin
          n_fail++;
          $display("FAIL scan_a t=%0t got=%b want=%b (de,rgb,hs,vs,vb,fs)", $time, obs_a, want);
        end
      end
      n_chk++;
      if (exp_qb.size() == 0) begin
        n_fail++;
        $display("FAIL scan_b t=%0t expected queue empty", $time);
      end else begin
        want = exp_qb.pop_front();
        if (obs_b !== want) begin
          n_fail++;
          $display("FAIL scan_b t=%0t got=%b want=%b (de,rgb,hs,vs,vb,fs)", $time, obs_b, want);
        end
      end
    end
  end

  initial begin
    int lo_len, hi_len, guard;
    n_chk  = 0;
    n_fail = 0;
    mon_on = 1'b0;
    s_a    = 0;
    s_b    = 0;
    en     = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 6'($urandom);

    repeat (3) @(posedge clk);
    #2;
    check_rst("reset_init");

    // Release: outputs after the first two edges still come from cleared pipeline stages.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      exp_qa.push_back(model_px(0, 0, 1'b0));
      exp_qb.push_back(model_px(1, 0, 1'b0));
    end
    drive(1'b1);
    @(posedge clk);
    mon_on = 1'b1;

    // Two full frames of the larger geometry, continuous scan.
    repeat (2 * f_tot(1) + 50) begin
      @(negedge clk);
      drive(1'b1);
    end

    // Random enable drops, including single-cycle ones, then restarts.
    for (int k = 0; k < 8; k++) begin
      lo_len = (k == 0) ? 1 : $urandom_range(1, 12);
      hi_len = $urandom_range(20, 1500);
      repeat (lo_len) begin
        @(negedge clk);
        drive(1'b0);
      end
      repeat (hi_len) begin
        @(negedge clk);
        drive(1'b1);
      end
    end

    // Run to a visible mid-line position of the 1x geometry before the asynchronous reset.
    guard = 0;
    while (!((s_b % h_tot(1) == 70) && (s_b / h_tot(1) >= 10) && (s_b / h_tot(1) < 120))
           && guard < f_tot(1)) begin
      @(negedge clk);
      drive(1'b1);
      guard++;
    end
    repeat (4) begin
      @(negedge clk);
      drive(1'b1);
    end
    @(posedge clk);
    mon_on = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_rst("reset_midline");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
